// File: rtl/adc_sample_sequencer.sv
// -----------------------------------------------------------------------------
// adc_sample_sequencer
//
// Controls a 4-comparator flash ADC front end. A conversion enables the
// comparator bank and waits SETTLE_CYCLES cycles. It then captures
// 2^AVG_LOG2 valid thermometer samples and presents their floor average on a
// valid/ready output port. A bubble code is not accumulated. The sample is
// retaken on the next cycle. MAX_BUBBLE consecutive bubbles abort the
// conversion with out_err set.
//
// Ports:
//   clk          system clock
//   reset        asynchronous active-high reset
//   start        request one conversion (sampled only while idle or on handshake)
//   cont_en      continuous mode: restart after each handshake
//   therm_in     comparator thermometer outputs, bit0 = lowest threshold
//   comp_en      comparator bank enable
//   busy         high whenever the sequencer is not idle
//   out_data     averaged 2-bit code
//   out_err      result aborted on bubble limit (qualified by out_valid)
//   out_valid    result available
//   out_ready    consumer accepts result
//   bubble_seen  sticky bubble indicator, cleared only by reset
// -----------------------------------------------------------------------------
module adc_sample_sequencer #(
    parameter int SETTLE_CYCLES = 4,
    parameter int AVG_LOG2      = 2,
    parameter int MAX_BUBBLE    = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       cont_en,
    input  logic [3:0] therm_in,
    output logic       comp_en,
    output logic       busy,
    output logic [1:0] out_data,
    output logic       out_err,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       bubble_seen
);

    localparam int ACC_W       = 2 + AVG_LOG2;
    localparam int CNT_W       = AVG_LOG2 + 1;
    localparam int NUM_SAMPLES = 1 << AVG_LOG2;
    localparam int SET_W       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int BUB_W       = $clog2(MAX_BUBBLE + 1);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    state_t             state_reg;
    logic [SET_W-1:0]   settle_cnt_reg;
    logic [ACC_W-1:0]   acc_reg;
    logic [CNT_W-1:0]   sample_cnt_reg;
    logic [BUB_W-1:0]   bubble_cnt_reg;
    logic               comp_en_reg;
    logic               busy_reg;
    logic [1:0]         out_data_reg;
    logic               out_err_reg;
    logic               out_valid_reg;
    logic               bubble_seen_reg;

    // A thermometer code is valid when no comparator is set above a cleared
    // one, i.e. each higher bit implies the bit below it.
    logic [2:0] order_ok;
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_order
            assign order_ok[gi] = therm_in[gi] | ~therm_in[gi+1];
        end
    endgenerate

    logic       therm_valid;
    logic [1:0] therm_code;
    assign therm_valid = &order_ok;
    // For a valid code the lowest comparator alone still encodes 0, so the
    // encoded value is the number of set bits among the upper three.
    assign therm_code  = {1'b0, therm_in[1]} + {1'b0, therm_in[2]} + {1'b0, therm_in[3]};

    logic [ACC_W-1:0] acc_next;
    logic [CNT_W-1:0] sample_cnt_next;
    logic [BUB_W-1:0] bubble_cnt_next;
    assign acc_next        = acc_reg + ACC_W'(therm_code);
    assign sample_cnt_next = sample_cnt_reg + CNT_W'(1);
    assign bubble_cnt_next = bubble_cnt_reg + BUB_W'(1);

    logic restart_req;
    assign restart_req = start | cont_en;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= IDLE;
            settle_cnt_reg  <= '0;
            acc_reg         <= '0;
            sample_cnt_reg  <= '0;
            bubble_cnt_reg  <= '0;
            comp_en_reg     <= 1'b0;
            busy_reg        <= 1'b0;
            out_data_reg    <= 2'd0;
            out_err_reg     <= 1'b0;
            out_valid_reg   <= 1'b0;
            bubble_seen_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (restart_req) begin
                        state_reg      <= SETTLE;
                        settle_cnt_reg <= SET_W'(SETTLE_CYCLES - 1);
                        acc_reg        <= '0;
                        sample_cnt_reg <= '0;
                        bubble_cnt_reg <= '0;
                        comp_en_reg    <= 1'b1;
                        busy_reg       <= 1'b1;
                    end
                end

                SETTLE: begin
                    if (settle_cnt_reg == '0) begin
                        state_reg <= SAMPLE;
                    end else begin
                        settle_cnt_reg <= settle_cnt_reg - SET_W'(1);
                    end
                end

                SAMPLE: begin
                    if (therm_valid) begin
                        acc_reg        <= acc_next;
                        sample_cnt_reg <= sample_cnt_next;
                        bubble_cnt_reg <= '0;
                        if (sample_cnt_next == CNT_W'(NUM_SAMPLES)) begin
                            state_reg     <= DONE;
                            // Floor average: the top two bits of the sum.
                            out_data_reg  <= acc_next[ACC_W-1 -: 2];
                            out_err_reg   <= 1'b0;
                            out_valid_reg <= 1'b1;
                            comp_en_reg   <= 1'b0;
                        end
                    end else begin
                        bubble_seen_reg <= 1'b1;
                        bubble_cnt_reg  <= bubble_cnt_next;
                        if (bubble_cnt_next == BUB_W'(MAX_BUBBLE)) begin
                            state_reg     <= DONE;
                            out_data_reg  <= 2'd0;
                            out_err_reg   <= 1'b1;
                            out_valid_reg <= 1'b1;
                            comp_en_reg   <= 1'b0;
                        end
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        if (restart_req) begin
                            state_reg      <= SETTLE;
                            settle_cnt_reg <= SET_W'(SETTLE_CYCLES - 1);
                            acc_reg        <= '0;
                            sample_cnt_reg <= '0;
                            bubble_cnt_reg <= '0;
                            comp_en_reg    <= 1'b1;
                        end else begin
                            state_reg <= IDLE;
                            busy_reg  <= 1'b0;
                        end
                    end
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign comp_en     = comp_en_reg;
    assign busy        = busy_reg;
    assign out_data    = out_data_reg;
    assign out_err     = out_err_reg;
    assign out_valid   = out_valid_reg;
    assign bubble_seen = bubble_seen_reg;

endmodule

// File: tb/tb_adc_sample_sequencer.sv
// -----------------------------------------------------------------------------
// tb_adc_sample_sequencer
//
// Testbench for adc_sample_sequencer with default parameters. A conversion
// model tracks the cycles elapsed since each start. From those cycles it
// derives the expected outputs on every clock, and a negedge compare process
// checks the DUT against it. Directed scenarios add literal expectations for
// timing, averaging, bubbles, abort, stall and async reset. A randomized phase
// follows them.
// -----------------------------------------------------------------------------
module tb_adc_sample_sequencer;

    localparam int S    = 4;   // settle cycles
    localparam int N    = 4;   // samples per result
    localparam int MAXB = 3;   // bubble abort limit

    logic       clk;
    logic       reset;
    logic       start;
    logic       cont_en;
    logic [3:0] therm_in;
    logic       comp_en;
    logic       busy;
    logic [1:0] out_data;
    logic       out_err;
    logic       out_valid;
    logic       out_ready;
    logic       bubble_seen;

    int n_cmp = 0;
    int n_bad = 0;

    adc_sample_sequencer #(
        .SETTLE_CYCLES(S),
        .AVG_LOG2     (2),
        .MAX_BUBBLE   (MAXB)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .cont_en    (cont_en),
        .therm_in   (therm_in),
        .comp_en    (comp_en),
        .busy       (busy),
        .out_data   (out_data),
        .out_err    (out_err),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .bubble_seen(bubble_seen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int decode(input logic [3:0] t);
        case (t)
            4'b0000, 4'b0001: return 0;
            4'b0011:          return 1;
            4'b0111:          return 2;
            4'b1111:          return 3;
            default:          return -1;
        endcase
    endfunction

    // ---------------- behavioural model ----------------
    // m_t counts edges since the conversion began. Edges 1..S are settle time,
    // and later edges each capture one sample.
    bit m_busy, m_valid, m_err, m_seen;
    int m_t, m_sum, m_n, m_bub, m_data;

    task automatic m_begin();
        m_busy = 1; m_t = 0; m_sum = 0; m_n = 0; m_bub = 0;
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy = 0; m_valid = 0; m_err = 0; m_seen = 0;
            m_t = 0; m_sum = 0; m_n = 0; m_bub = 0; m_data = 0;
        end else if (!m_busy) begin
            if (start || cont_en) m_begin();
        end else if (m_valid) begin
            if (out_ready) begin
                m_valid = 0;
                if (start || cont_en) m_begin();
                else m_busy = 0;
            end
        end else begin
            m_t++;
            if (m_t > S) begin
                if (decode(therm_in) >= 0) begin
                    m_sum += decode(therm_in);
                    m_n++;
                    m_bub = 0;
                    if (m_n == N) begin
                        m_valid = 1; m_data = m_sum / N; m_err = 0;
                    end
                end else begin
                    m_bub++;
                    m_seen = 1;
                    if (m_bub == MAXB) begin
                        m_valid = 1; m_data = 0; m_err = 1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("comp_en", int'(comp_en), int'(m_busy && !m_valid));
            chk("busy", int'(busy), int'(m_busy));
            chk("out_valid", int'(out_valid), int'(m_valid));
            chk("bubble_seen", int'(bubble_seen), int'(m_seen));
            if (m_valid) begin
                chk("out_data", int'(out_data), m_data);
                chk("out_err", int'(out_err), int'(m_err));
            end
        end
    end

    // One conversion from idle: start pulse at E0, then feed nsamp therm values
    // (lowest nibble first) on successive sample edges.
    task automatic run_conv(input string nm, input logic [31:0] seq, input int nsamp,
                            input int exp_data, input int exp_err);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk({nm, "_comp_en_E0"}, int'(comp_en), 1);
        repeat (S) @(negedge clk);
        chk({nm, "_busy_settled"}, int'(busy), 1);
        for (int i = 0; i < nsamp; i++) begin
            therm_in = seq[4*i +: 4];
            if (i == nsamp - 1) chk({nm, "_valid_early"}, int'(out_valid), 0);
            @(negedge clk);
        end
        chk({nm, "_valid"}, int'(out_valid), 1);
        chk({nm, "_data"}, int'(out_data), exp_data);
        chk({nm, "_err"}, int'(out_err), exp_err);
        chk({nm, "_comp_en_done"}, int'(comp_en), 0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({nm, "_valid_after_hs"}, int'(out_valid), 0);
        chk({nm, "_busy_after_hs"}, int'(busy), 0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; cont_en = 1'b0; therm_in = 4'b0000; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_comp_en", int'(comp_en), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_data", int'(out_data), 0);
        chk("rst_err", int'(out_err), 0);
        chk("rst_bubble_seen", int'(bubble_seen), 0);

        run_conv("fixed0111", 32'h0000_7777, 4, 2, 0);
        run_conv("sum8", 32'h0000_33FF, 4, 2, 0);
        run_conv("sum10", 32'h0000_77FF, 4, 2, 0);
        run_conv("zero", 32'h0000_0000, 4, 0, 0);
        run_conv("full", 32'h0000_FFFF, 4, 3, 0);
        run_conv("lowbit", 32'h0000_1111, 4, 0, 0);
        chk("no_bubble_yet", int'(bubble_seen), 0);
        run_conv("bubble", 32'h000F_FF5F, 5, 3, 0);
        chk("bubble_sticky", int'(bubble_seen), 1);
        run_conv("abort", 32'h0000_0AAA, 3, 0, 1);

        // Continuous mode with a stalled consumer and a start pulse in SAMPLE.
        therm_in = 4'b0111;
        cont_en = 1'b1;
        @(negedge clk);                       // E0 occurs next
        @(negedge clk);
        repeat (S) @(negedge clk);            // after E4
        start = 1'b1; @(negedge clk); start = 1'b0;   // pulse lands in SAMPLE
        repeat (3) @(negedge clk);            // after E8
        chk("cont_valid", int'(out_valid), 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_valid", int'(out_valid), 1);
            chk("stall_data", int'(out_data), 2);
        end
        out_ready = 1'b1;
        @(negedge clk);                       // handshake edge = new E0
        out_ready = 1'b0;
        cont_en = 1'b0;
        chk("cont_restart_valid", int'(out_valid), 0);
        chk("cont_restart_comp_en", int'(comp_en), 1);
        chk("cont_restart_busy", int'(busy), 1);
        repeat (7) @(negedge clk);
        chk("cont_second_early", int'(out_valid), 0);
        @(negedge clk);
        chk("cont_second_valid", int'(out_valid), 1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("cont_stop_busy", int'(busy), 0);
        repeat (3) @(negedge clk);
        chk("no_extra_conv", int'(busy), 0);

        // Asynchronous reset in the middle of SAMPLE.
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (S + 2) @(negedge clk);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("arst_comp_en", int'(comp_en), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_valid", int'(out_valid), 0);
        chk("arst_bubble_seen", int'(bubble_seen), 0);
        @(negedge clk); @(negedge clk);
        #2 reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("post_rst_valid", int'(out_valid), 0);
            chk("post_rst_busy", int'(busy), 0);
        end

        // Randomized traffic checked by the model every cycle.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            start     = ($urandom_range(0, 7) == 0);
            cont_en   = ($urandom_range(0, 9) < 2);
            out_ready = $urandom_range(0, 1);
            if ($urandom_range(0, 5) == 0) begin
                therm_in = 4'($urandom_range(0, 15));
            end else begin
                case ($urandom_range(0, 4))
                    0: therm_in = 4'b0000;
                    1: therm_in = 4'b0001;
                    2: therm_in = 4'b0011;
                    3: therm_in = 4'b0111;
                    default: therm_in = 4'b1111;
                endcase
            end
        end
        start = 1'b0; cont_en = 1'b0;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
